// File: rtl/delay_arb_if.sv
// Bundle of requester, delay-line and result signals for delay_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface delay_arb_if;
    logic [1:0] req;
    logic [3:0] delay_0;
    logic [3:0] delay_1;
    logic       data_0;
    logic       data_1;
    logic [1:0] gnt;
    logic [1:0] take;
    logic [1:0] done;
    logic       dl_data;
    logic [3:0] dl_delay;
    logic       dl_return;
    logic       data;
    logic       valid;
    logic       id;

    modport slave (
        input  req, delay_0, delay_1, data_0, data_1, dl_return,
        output gnt, take, done, dl_data, dl_delay, data, valid, id
    );

    modport master (
        output req, delay_0, delay_1, data_0, data_1, dl_return,
        input  gnt, take, done, dl_data, dl_delay, data, valid, id
    );
endinterface

// File: rtl/delay_arb.sv
// Round-robin arbiter that streams a granted requester's serial burst through a
// shared delay line of latency dl_delay+1 and flags the returning bits as valid.
module delay_arb #(
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    delay_arb_if.slave  bus
);
    localparam int CW = $clog2(BURST_LEN + 17);
    localparam logic [CW-1:0] BURST_END = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          last_r, last_s;
    logic          win_r, win_s;
    logic [3:0]    delay_r, delay_s;
    logic          pick_s;
    logic [CW-1:0] lat_s, end_s;
    logic [1:0]    gnt_r, gnt_s;
    logic [1:0]    take_r, take_s;
    logic [1:0]    done_r, done_s;
    logic          valid_r, valid_s;
    logic          id_r;

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Winner selection: a lone requester wins, a tie goes to the one not last served
    always_comb begin
        pick_s = 1'b0;
        case (bus.req)
            2'b01:   pick_s = 1'b0;
            2'b10:   pick_s = 1'b1;
            default: pick_s = ~last_r;
        endcase
    end

    // Next state, counter, grant bookkeeping and next values of registered outputs
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        win_s   = win_r;
        delay_s = delay_r;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (bus.req != 2'b00) begin
                    state_s = LOAD;
                    win_s   = pick_s;
                    last_s  = pick_s;
                    delay_s = pick_s ? bus.delay_1 : bus.delay_0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = STREAM;
                cnt_s   = '0;
            end
            STREAM: begin
                cnt_s = cnt_r + CW'(1);
                if (cnt_r == BURST_END) begin
                    state_s = DRAIN;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                // Last drain cycle is cnt = BURST_LEN + L - 1 = BURST_LEN + delay
                if (cnt_r == CW'(BURST_LEN) + CW'(delay_r)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    state_s = DRAIN;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase

        lat_s   = CW'(delay_s) + CW'(1);
        end_s   = CW'(BURST_LEN) + CW'(delay_s);
        gnt_s   = (state_s != IDLE) ? onehot(win_s) : 2'b00;
        take_s  = (state_s == STREAM) ? onehot(win_s) : 2'b00;
        done_s  = (state_s == DRAIN && cnt_s == end_s) ? onehot(win_s) : 2'b00;
        valid_s = (state_s == STREAM || state_s == DRAIN) &&
                  (cnt_s >= lat_s) && (cnt_s <= end_s);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            last_r  <= 1'b1;
            win_r   <= 1'b0;
            delay_r <= 4'd0;
            gnt_r   <= 2'b00;
            take_r  <= 2'b00;
            done_r  <= 2'b00;
            valid_r <= 1'b0;
            id_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            win_r   <= win_s;
            delay_r <= delay_s;
            gnt_r   <= gnt_s;
            take_r  <= take_s;
            done_r  <= done_s;
            valid_r <= valid_s;
            id_r    <= win_s;
        end
    end

    // The taken bit must enter the delay line in the same cycle it is consumed
    assign bus.dl_data  = (take_r[0] & bus.data_0) | (take_r[1] & bus.data_1);
    assign bus.dl_delay = delay_r;
    assign bus.data     = bus.dl_return;
    assign bus.gnt      = gnt_r;
    assign bus.take     = take_r;
    assign bus.done     = done_r;
    assign bus.valid    = valid_r;
    assign bus.id       = id_r;
endmodule

// File: tb/tb_delay_arb.sv
// Directed and randomized bench for delay_arb with a behavioural delay line and
// a burst-level reference model (round-robin pointer, timing windows, bit queue).
module tb_delay_arb;
    localparam int B = 8;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] hist = 16'd0;
    int checks = 0;
    int errors = 0;
    bit ptr_last = 1'b1;
    logic exp_q[$];

    delay_arb_if bus();

    delay_arb #(.BURST_LEN(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared delay line: bit presented in cycle t returns in cycle t + dl_delay + 1
    always @(posedge clk) hist <= {hist[14:0], bus.dl_data};
    assign bus.dl_return = hist[bus.dl_delay];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_take"}, bus.take, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_dl_data"}, bus.dl_data, 0);
        chk({tag, "_dl_delay"}, bus.dl_delay, 0);
        chk({tag, "_id"}, bus.id, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req = 2'b00;
            step();
            chk("idle_gnt", bus.gnt, 0);
            chk("idle_valid", bus.valid, 0);
        end
    endtask

    // One burst, entered while the DUT sits in IDLE; pat[k] is the k-th bit streamed
    task automatic burst(input logic [1:0] req, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [63:0] pat, input int abort_at, input bit perturb);
        int win, lat, cnt, vcount;
        logic [3:0] dsel;
        logic b;
        bit in_stream, exp_valid;
        win = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : (ptr_last ? 0 : 1);
        ptr_last = (win == 1);
        dsel = win ? d1 : d0;
        lat = int'(dsel) + 1;
        exp_q.delete();
        vcount = 0;
        b = 1'b0;
        chk("pre_gnt", bus.gnt, 0);
        chk("pre_valid", bus.valid, 0);
        bus.req = req;
        bus.delay_0 = d0;
        bus.delay_1 = d1;
        for (int j = 0; j <= B + lat; j++) begin
            step();
            if (perturb) begin
                bus.req = 2'($urandom);
                bus.delay_0 = 4'($urandom);
                bus.delay_1 = 4'($urandom);
            end
            if (j == 3) bus.delay_0 = 4'd3;
            in_stream = (j >= 1) && (j <= B);
            cnt = j - 1;
            bus.data_0 = 1'($urandom);
            bus.data_1 = 1'($urandom);
            if (in_stream) begin
                b = pat[cnt];
                if (win == 1) bus.data_1 = b;
                else bus.data_0 = b;
                exp_q.push_back(b);
            end
            #1;
            chk("gnt", bus.gnt, win ? 2 : 1);
            chk("take", bus.take, in_stream ? (win ? 2 : 1) : 0);
            chk("dl_data", bus.dl_data, in_stream ? b : 1'b0);
            chk("dl_delay", bus.dl_delay, dsel);
            chk("done", bus.done, (j == B + lat) ? (win ? 2 : 1) : 0);
            exp_valid = (j >= 1) && (cnt >= lat) && (cnt <= B + lat - 1);
            chk("valid", bus.valid, exp_valid);
            if (exp_valid) begin
                chk("queue_has_bit", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("data", bus.data, exp_q.pop_front());
                chk("id", bus.id, win);
                vcount++;
            end
            if (abort_at >= 0 && in_stream && cnt == abort_at) begin
                rst = 1'b1;
                #1;
                chk_all_zero("abort");
                ptr_last = 1'b1;
                step();
                chk_all_zero("abort_hold");
                rst = 1'b0;
                return;
            end
        end
        chk("valid_count", vcount, B);
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 2'b00;
        bus.delay_0 = 4'd0;
        bus.delay_1 = 4'd0;
        bus.data_0 = 1'b0;
        bus.data_1 = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Requester 0, longest delay; time-order pattern 0111_1001
        burst(2'b01, 4'd15, 4'd0, 64'b1001_1110, -1, 1'b0);
        idle(2);
        // Requester 1, shortest delay, with requests and delays churning mid-burst
        burst(2'b10, 4'd0, 4'd0, {$urandom, $urandom}, -1, 1'b1);
        // Both requesting back to back: alternate starting with requester 0
        for (int i = 0; i < 3; i++)
            burst(2'b11, 4'($urandom), 4'($urandom), {$urandom, $urandom}, -1, 1'b0);
        idle(1);
        // Abort at cnt 5, then a tie must again go to requester 0
        burst(2'b10, 4'd5, 4'd5, {$urandom, $urandom}, 5, 1'b0);
        burst(2'b11, 4'd2, 4'd9, {$urandom, $urandom}, -1, 1'b0);
        chk("after_abort_ptr", ptr_last, 0);
        for (int i = 0; i < 3; i++)
            burst(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, -1, 1'b1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
